// File: rtl/flappy_pkg.sv
// Shared definitions for the flappybird game core: FSM encodings and
// default screen / pipe geometry used by the pipe scheduler and its slots.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int DEF_NPIPE     = 3;
    localparam int DEF_XW        = 10;
    localparam int DEF_YW        = 9;
    localparam int DEF_SPAWN_X   = 640;
    localparam int DEF_PIPE_W    = 52;
    localparam int DEF_SPEED     = 2;
    localparam int DEF_SPACING   = 110;
    localparam int DEF_GAP_MIN   = 80;
    localparam int DEF_RND_SHIFT = 1;
    localparam int DEF_BIRD_X    = 160;

endpackage

// File: rtl/pipe_slot.sv
// One pipe slot: holds x / gap / valid, scrolls and retires the pipe on step,
// and flags when this step carries the pipe's right edge past the bird.
module pipe_slot
    import flappy_pkg::*;
#(
    parameter int XW      = DEF_XW,
    parameter int YW      = DEF_YW,
    parameter int SPAWN_X = DEF_SPAWN_X,
    parameter int PIPE_W  = DEF_PIPE_W,
    parameter int SPEED   = DEF_SPEED,
    parameter int BIRD_X  = DEF_BIRD_X
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic          load,
    input  logic [YW-1:0] load_gap,
    output logic          valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] gap,
    output logic          pass_hit
);

    // load only ever targets a free slot, so it never competes with a move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            x     <= '0;
            gap   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            x     <= '0;
            gap   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            x     <= XW'(SPAWN_X);
            gap   <= load_gap;
        end else if (step && valid) begin
            if (x < XW'(SPEED))
                valid <= 1'b0;
            else
                x <= x - XW'(SPEED);
        end
    end

    // right edge strictly right of the bird now, at or left of it after the move
    assign pass_hit = valid
                   && (int'(x) + PIPE_W > BIRD_X)
                   && (int'(x) + PIPE_W - SPEED <= BIRD_X);

endmodule

// File: rtl/pipe_scheduler.sv
// Spawns, scrolls and retires pipes from the random byte stream; holds the
// game FSM, spawn cadence counter and lowest-free-slot selection.
module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter int NPIPE     = DEF_NPIPE,
    parameter int XW        = DEF_XW,
    parameter int YW        = DEF_YW,
    parameter int SPAWN_X   = DEF_SPAWN_X,
    parameter int PIPE_W    = DEF_PIPE_W,
    parameter int SPEED     = DEF_SPEED,
    parameter int SPACING   = DEF_SPACING,
    parameter int GAP_MIN   = DEF_GAP_MIN,
    parameter int RND_SHIFT = DEF_RND_SHIFT,
    parameter int BIRD_X    = DEF_BIRD_X
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic                crash,
    input  logic [7:0]          rnd,
    output logic                rnd_take,
    output logic [NPIPE-1:0]    pipe_valid,
    output logic [NPIPE*XW-1:0] pipe_x,
    output logic [NPIPE*YW-1:0] pipe_gap,
    output logic                pass,
    output logic                running,
    output state_t              state_dbg
);

    localparam int CW = ($clog2(SPACING) > 0) ? $clog2(SPACING) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPACING - 1);

    state_t            state, state_n;
    logic              enter_run, step, have_free, spawn;
    logic [CW-1:0]     cnt;
    logic [NPIPE-1:0]  load_vec, hit_vec;
    logic [YW-1:0]     spawn_gap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // crash beats tick in RUN; start beats crash in HALT
    always_comb begin
        state_n   = state;
        enter_run = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_n   = ST_RUN;
                enter_run = 1'b1;
            end
            ST_RUN: begin
                if (crash)     state_n = ST_HALT;
                else if (tick) step    = 1'b1;
            end
            ST_HALT: if (start) begin
                state_n   = ST_RUN;
                enter_run = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // a slot retiring on this tick still reads as occupied here
    always_comb begin
        load_vec  = '0;
        have_free = 1'b0;
        for (int i = 0; i < NPIPE; i++) begin
            if (!pipe_valid[i] && !have_free) begin
                load_vec[i] = 1'b1;
                have_free   = 1'b1;
            end
        end
    end

    assign spawn     = step && (cnt == CNT_LAST) && have_free;
    assign spawn_gap = YW'(GAP_MIN) + YW'(rnd >> RND_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (enter_run)
            cnt <= CNT_LAST;
        else if (step) begin
            if (spawn)                cnt <= '0;
            else if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pass <= 1'b0;
        else     pass <= step && (|hit_vec);
    end

    assign rnd_take  = spawn;
    assign running   = (state == ST_RUN);
    assign state_dbg = state;

    for (genvar g = 0; g < NPIPE; g++) begin : g_slot
        pipe_slot #(
            .XW(XW), .YW(YW), .SPAWN_X(SPAWN_X), .PIPE_W(PIPE_W),
            .SPEED(SPEED), .BIRD_X(BIRD_X)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .clear    (enter_run),
            .step     (step),
            .load     (spawn && load_vec[g]),
            .load_gap (spawn_gap),
            .valid    (pipe_valid[g]),
            .x        (pipe_x[g*XW +: XW]),
            .gap      (pipe_gap[g*YW +: YW]),
            .pass_hit (hit_vec[g])
        );
    end

endmodule
